// File: rtl/led_switch_ctrl.sv
// Debounced switch front end driving per-channel LEDs in four display modes,
// with press pulses, per-channel toggles and a prescaled blink pattern on LED_USER.
module led_switch_ctrl #(
   parameter int unsigned N_CH            = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned TICK_W          = 21,
   parameter logic [31:0] PATTERN         = 32'b0000_0101_0100_0111_0111_0111_0001_0101
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [N_CH-1:0] SW,
   input  logic [1:0]      MODE,
   output logic [N_CH-1:0] LED,
   output logic            LED_USER,
   output logic [N_CH-1:0] PRESS
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_CH-1:0]   s1_r;
   logic [N_CH-1:0]   s2_r;
   logic [N_CH-1:0]   stb_r;
   logic [N_CH-1:0]   stb_d_r;
   logic [N_CH-1:0]   tgl_r;
   logic [CNT_W-1:0]  cnt_r [N_CH];
   logic [TICK_W-1:0] presc_r;
   logic [4:0]        idx_r;

   logic [N_CH-1:0]   stb_nxt_s;
   logic [CNT_W-1:0]  cnt_nxt_s [N_CH];
   logic [N_CH-1:0]   rise_s;
   logic [N_CH-1:0]   led_nxt_s;
   logic              blink_s;
   logic              tick_s;

   // Reduce view: bits 0..2 replaced by OR, AND and XOR of all accepted levels.
   function automatic logic [N_CH-1:0] reduce_map(input logic [N_CH-1:0] v);
      logic [N_CH-1:0] r;
      r    = v;
      r[0] = |v;
      r[1] = &v;
      r[2] = ^v;
      return r;
   endfunction

   assign rise_s  = stb_r & ~stb_d_r;
   assign blink_s = PATTERN[idx_r];
   assign tick_s  = &presc_r;

   // Debounce next state: a level is accepted only after DEBOUNCE_CYCLES disagreeing samples in a row.
   always_comb begin
      stb_nxt_s = stb_r;
      for (int i = 0; i < int'(N_CH); i++) begin
         cnt_nxt_s[i] = {CNT_W{1'b0}};
         if (s2_r[i] == stb_r[i]) begin
            cnt_nxt_s[i] = {CNT_W{1'b0}};
         end else if (cnt_r[i] == CNT_MAX) begin
            stb_nxt_s[i] = s2_r[i];
            cnt_nxt_s[i] = {CNT_W{1'b0}};
         end else begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
         end
      end
   end

   // LED source selection; MODE is used directly so a change shows on the next edge.
   always_comb begin
      led_nxt_s = stb_r;
      case (MODE)
         2'd0:    led_nxt_s = stb_r;
         2'd1:    led_nxt_s = tgl_r;
         2'd2:    led_nxt_s = stb_r & {N_CH{blink_s}};
         2'd3:    led_nxt_s = reduce_map(stb_r);
         default: led_nxt_s = stb_r;
      endcase
   end

   // All state and registered outputs; reset abandons any debounce or pattern progress.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_r     <= {N_CH{1'b0}};
         s2_r     <= {N_CH{1'b0}};
         stb_r    <= {N_CH{1'b0}};
         stb_d_r  <= {N_CH{1'b0}};
         tgl_r    <= {N_CH{1'b0}};
         presc_r  <= {TICK_W{1'b0}};
         idx_r    <= 5'd0;
         LED      <= {N_CH{1'b0}};
         PRESS    <= {N_CH{1'b0}};
         LED_USER <= 1'b0;
         for (int i = 0; i < int'(N_CH); i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end
      end else begin
         s1_r     <= SW;
         s2_r     <= s1_r;
         stb_r    <= stb_nxt_s;
         stb_d_r  <= stb_r;
         tgl_r    <= tgl_r ^ rise_s;
         presc_r  <= presc_r + TICK_W'(1);
         idx_r    <= tick_s ? (idx_r + 5'd1) : idx_r;
         LED      <= led_nxt_s;
         PRESS    <= rise_s;
         LED_USER <= blink_s;
         for (int i = 0; i < int'(N_CH); i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

endmodule

// File: tb/tb_led_switch_ctrl.sv
// Randomized and directed bench for led_switch_ctrl with a window-based reference model.
module tb_led_switch_ctrl;

   localparam int          NCH = 4;
   localparam int          DEB = 4;
   localparam int          TW  = 3;
   localparam logic [31:0] PAT = 32'b0000_0101_0100_0111_0111_0111_0001_0101;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] SW = 4'b0000;
   logic [1:0] MODE = 2'd0;
   logic [3:0] LED;
   logic       LED_USER;
   logic [3:0] PRESS;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [31:0] pat_v = PAT;
   logic [31:0] mask_v = (32'd1 << DEB) - 32'd1;
   logic [3:0]  m_s1, m_s2, m_stb, m_stb_old;
   logic [31:0] hist_bits [NCH];
   int          hist_len [NCH];
   int          press_cnt [NCH];
   int          ncyc;
   logic [3:0]  exp_led, exp_press;
   logic        exp_user;

   led_switch_ctrl #(
      .N_CH(NCH), .DEBOUNCE_CYCLES(DEB), .TICK_W(TW), .PATTERN(PAT)
   ) dut (
      .CLK(CLK), .RST(RST), .SW(SW), .MODE(MODE),
      .LED(LED), .LED_USER(LED_USER), .PRESS(PRESS)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs the DUT samples at that edge.
   task automatic model_edge();
      logic [3:0] tgl_v;
      logic [3:0] nstb;
      logic [31:0] win;
      int idx_pre;
      if (RST) begin
         m_s1 = 4'b0; m_s2 = 4'b0; m_stb = 4'b0; m_stb_old = 4'b0;
         exp_led = 4'b0; exp_press = 4'b0; exp_user = 1'b0; ncyc = 0;
         for (int i = 0; i < NCH; i++) begin
            hist_bits[i] = 32'b0; hist_len[i] = 0; press_cnt[i] = 0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) tgl_v[i] = press_cnt[i][0];
         idx_pre  = (ncyc / 8) % 32;
         exp_user = pat_v[idx_pre];
         case (MODE)
            2'd0:    exp_led = m_stb;
            2'd1:    exp_led = tgl_v;
            2'd2:    exp_led = exp_user ? m_stb : 4'b0000;
            default: exp_led = {m_stb[3], ^m_stb, &m_stb, |m_stb};
         endcase
         exp_press = m_stb & ~m_stb_old;
         for (int i = 0; i < NCH; i++) if (exp_press[i]) press_cnt[i]++;
         nstb = m_stb;
         for (int i = 0; i < NCH; i++) begin
            hist_bits[i] = {hist_bits[i][30:0], m_s2[i]};
            if (hist_len[i] < 32) hist_len[i]++;
            win = hist_bits[i] & mask_v;
            if (hist_len[i] >= DEB && (m_stb[i] ? (win == 32'd0) : (win == mask_v))) begin
               nstb[i] = m_s2[i];
               hist_bits[i] = 32'b0;
               hist_len[i] = 0;
            end
         end
         m_stb_old = m_stb;
         m_stb     = nstb;
         m_s2      = m_s1;
         m_s1      = SW;
         ncyc++;
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      check_val("led", {28'b0, LED}, {28'b0, exp_led});
      check_val("press", {28'b0, PRESS}, {28'b0, exp_press});
      check_val("led_user", {31'b0, LED_USER}, {31'b0, exp_user});
   endtask

   initial begin
      // reset state
      RST = 1'b1; SW = 4'b0000; MODE = 2'd0;
      step(); step();
      check_val("rst_led", {28'b0, LED}, 32'd0);
      check_val("rst_press", {28'b0, PRESS}, 32'd0);
      check_val("rst_user", {31'b0, LED_USER}, 32'd0);
      RST = 1'b0;
      repeat (4) step();

      // passthrough latency: accept at k+DEB+1, LED/PRESS at k+DEB+2
      SW = 4'b0001;
      step();
      repeat (DEB) step();
      step();
      check_val("lat_led_early", {28'b0, LED}, 32'd0);
      step();
      check_val("lat_led", {28'b0, LED}, 32'd1);
      check_val("lat_press", {28'b0, PRESS}, 32'd1);
      step();
      check_val("lat_press_end", {28'b0, PRESS}, 32'd0);

      // short glitch on channel 1 is rejected
      SW = 4'b0011;
      repeat (3) step();
      SW = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         step();
         check_val("glitch_led", {28'b0, LED}, 32'd1);
         check_val("glitch_press", {28'b0, PRESS}, 32'd0);
      end

      // toggle mode: three presses on channel 2, retained over a mode change
      SW = 4'b0000;
      repeat (12) step();
      MODE = 2'd1;
      for (int p = 0; p < 3; p++) begin
         SW = 4'b0100;
         repeat (10) step();
         check_val("tgl_seq", {31'b0, LED[2]}, (p % 2 == 0) ? 32'd1 : 32'd0);
         SW = 4'b0000;
         repeat (10) step();
      end
      MODE = 2'd0;
      repeat (5) step();
      MODE = 2'd1;
      step();
      check_val("tgl_keep", {31'b0, LED[2]}, 32'd1);

      // reduce mode
      MODE = 2'd3;
      SW = 4'b1011;
      repeat (10) step();
      check_val("reduce_1011", {28'b0, LED}, 32'hD);
      SW = 4'b1111;
      repeat (10) step();
      check_val("reduce_1111", {28'b0, LED}, 32'hB);

      // free-running pattern after reset, including the index wrap
      SW = 4'b0000; MODE = 2'd0; RST = 1'b1;
      step();
      RST = 1'b0;
      for (int j = 1; j <= 257; j++) begin
         step();
         if (j == 256) check_val("pat_last", {31'b0, LED_USER}, {31'b0, pat_v[31]});
         if (j == 257) check_val("pat_wrap", {31'b0, LED_USER}, {31'b0, pat_v[0]});
      end

      // reset mid-debounce with a toggle set
      MODE = 2'd1;
      SW = 4'b0100;
      repeat (10) step();
      SW = 4'b0000;
      repeat (10) step();
      check_val("pre_rst_tgl", {28'b0, LED}, 32'h4);
      SW = 4'b0001;
      repeat (3) step();
      RST = 1'b1;
      step();
      check_val("mid_rst_led", {28'b0, LED}, 32'd0);
      check_val("mid_rst_press", {28'b0, PRESS}, 32'd0);
      check_val("mid_rst_user", {31'b0, LED_USER}, 32'd0);
      RST = 1'b0;
      step();
      check_val("post_rst_tgl", {28'b0, LED}, 32'd0);
      for (int c = 0; c < DEB + 1; c++) begin
         step();
         check_val("post_rst_wait", {28'b0, PRESS}, 32'd0);
      end
      step();
      check_val("post_rst_press", {28'b0, PRESS}, 32'd1);
      step();
      check_val("post_rst_tgl1", {28'b0, LED}, 32'd1);

      // randomized segments: holds of varying length, mode changes, rare resets
      for (int s = 0; s < 600; s++) begin
         int hold;
         SW   = 4'($urandom_range(0, 15));
         MODE = 2'($urandom_range(0, 3));
         hold = $urandom_range(1, 12);
         if ($urandom_range(0, 59) == 0) begin
            RST = 1'b1;
            step();
            RST = 1'b0;
         end
         for (int c = 0; c < hold; c++) begin
            if ($urandom_range(0, 7) == 0) MODE = 2'($urandom_range(0, 3));
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
